// File: rtl/quad_encoder_pkg.sv
// Shared encodings and helpers for the quadrature encoder array:
// quadrature state/step encodings, x4 step decoding and signed saturation.
package quad_encoder_pkg;

  typedef enum logic [1:0] {
    QS_00 = 2'b00,
    QS_01 = 2'b01,
    QS_10 = 2'b10,
    QS_11 = 2'b11
  } quad_state_e;

  typedef enum logic [1:0] {
    STEP_NONE = 2'b00,
    STEP_FWD  = 2'b01,
    STEP_REV  = 2'b10,
    STEP_ERR  = 2'b11
  } step_e;

  // Widest intermediate the saturation helper accepts (POS_WIDTH must stay below it).
  localparam int SAT_W = 64;

  // Forward x4 sequence on {A,B}: 00 -> 10 -> 11 -> 01 -> 00.
  function automatic logic [1:0] fwd_next(input logic [1:0] st);
    logic [1:0] n;
    case (st)
      QS_00:   n = QS_10;
      QS_10:   n = QS_11;
      QS_11:   n = QS_01;
      default: n = QS_00;
    endcase
    return n;
  endfunction

  function automatic step_e decode_step(input logic [1:0] prev, input logic [1:0] curr);
    step_e s;
    if (prev == curr)                 s = STEP_NONE;
    else if ((prev ^ curr) == 2'b11)  s = STEP_ERR;
    else if (curr == fwd_next(prev))  s = STEP_FWD;
    else                              s = STEP_REV;
    return s;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_signed(input logic signed [SAT_W:0] val,
                                                         input int unsigned out_w);
    logic signed [SAT_W:0]   hi;
    logic signed [SAT_W:0]   lo;
    logic signed [SAT_W-1:0] res;
    hi = ((SAT_W+1)'(1) <<< (out_w - 1)) - (SAT_W+1)'(1);
    lo = -hi - (SAT_W+1)'(1);
    if (val > hi)      res = hi[SAT_W-1:0];
    else if (val < lo) res = lo[SAT_W-1:0];
    else               res = val[SAT_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/quad_encoder_channel.sv
// One encoder channel: 2-flop synchronisers, per-line glitch filter, x4 decoder,
// wrapping position counter and sticky illegal-transition flag.
module quad_encoder_channel
  import quad_encoder_pkg::*;
#(
  parameter int POS_WIDTH     = 32,
  parameter int FILTER_CYCLES = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 a_i,
  input  logic                 b_i,
  input  logic                 clear_i,
  input  logic                 err_clr_i,
  output logic [POS_WIDTH-1:0] pos_o,
  output logic                 err_o
);

  localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic [1:0]           sync1_q, sync2_q;
  logic [1:0]           filt_q, filt_d;
  logic [1:0]           ref_q, ref_d;
  logic [CNT_W-1:0]     cnt_q [2];
  logic [CNT_W-1:0]     cnt_d [2];
  logic [1:0]           prime_q, prime_d;
  logic                 primed_q, primed_d;
  logic [POS_WIDTH-1:0] pos_q, pos_d;
  logic                 err_q, err_d;
  step_e                step;

  // Until primed the filter is bypassed so the first accepted level is taken as-is.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    for (int l = 0; l < 2; l++) begin
      if (!primed_q) begin
        filt_d[l] = sync2_q[l];
        cnt_d[l]  = '0;
      end else if (sync2_q[l] == filt_q[l]) begin
        cnt_d[l]  = '0;
      end else if (cnt_q[l] == CNT_LAST) begin
        filt_d[l] = sync2_q[l];
        cnt_d[l]  = '0;
      end else begin
        cnt_d[l]  = cnt_q[l] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    primed_d = primed_q | (prime_q == 2'd2);
    prime_d  = (primed_q || prime_q == 2'd2) ? prime_q : prime_q + 2'd1;
    ref_d    = primed_q ? filt_q : filt_d;
    step     = primed_q ? decode_step(ref_q, filt_q) : STEP_NONE;

    pos_d = pos_q;
    if (clear_i)                pos_d = '0;
    else if (step == STEP_FWD)  pos_d = pos_q + POS_WIDTH'(1);
    else if (step == STEP_REV)  pos_d = pos_q - POS_WIDTH'(1);

    err_d = err_q;
    if (step == STEP_ERR)  err_d = 1'b1;
    else if (err_clr_i)    err_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      filt_q   <= '0;
      ref_q    <= '0;
      cnt_q    <= '{default: '0};
      prime_q  <= '0;
      primed_q <= 1'b0;
      pos_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      sync1_q  <= {a_i, b_i};
      sync2_q  <= sync1_q;
      filt_q   <= filt_d;
      ref_q    <= ref_d;
      cnt_q    <= cnt_d;
      prime_q  <= prime_d;
      primed_q <= primed_d;
      pos_q    <= pos_d;
      err_q    <= err_d;
    end
  end

  assign pos_o = pos_q;
  assign err_o = err_q;

endmodule

// File: rtl/quad_encoder_array.sv
// Array of quadrature encoder channels with a shared velocity timebase;
// velocity is the per-window position delta, saturated to VEL_WIDTH.
module quad_encoder_array
  import quad_encoder_pkg::*;
#(
  parameter int CHANNELS      = 2,
  parameter int POS_WIDTH     = 32,
  parameter int FILTER_CYCLES = 4,
  parameter int VEL_PERIOD    = 100000,
  parameter int VEL_WIDTH     = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [CHANNELS-1:0]           channelA,
  input  logic [CHANNELS-1:0]           channelB,
  input  logic [CHANNELS-1:0]           clear,
  input  logic [CHANNELS-1:0]           error_clear,
  output logic [CHANNELS*POS_WIDTH-1:0] position,
  output logic [CHANNELS*VEL_WIDTH-1:0] velocity,
  output logic                          velocity_valid,
  output logic [CHANNELS-1:0]           error
);

  localparam int TB_W = $clog2(VEL_PERIOD);
  localparam logic [TB_W-1:0] TB_LAST = TB_W'(VEL_PERIOD - 1);

  logic [TB_W-1:0] tb_q, tb_d;
  logic            tc;
  logic            vld_q;

  always_comb begin
    tc   = (tb_q == TB_LAST);
    tb_d = tc ? '0 : tb_q + TB_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tb_q  <= '0;
      vld_q <= 1'b0;
    end else begin
      tb_q  <= tb_d;
      vld_q <= tc;
    end
  end

  assign velocity_valid = vld_q;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [POS_WIDTH-1:0]  pos_w;
    logic [POS_WIDTH-1:0]  prev_q, prev_d;
    logic [VEL_WIDTH-1:0]  vel_q, vel_d;
    logic [POS_WIDTH:0]    diff;
    logic signed [SAT_W:0] diff_ext;

    quad_encoder_channel #(
      .POS_WIDTH     (POS_WIDTH),
      .FILTER_CYCLES (FILTER_CYCLES)
    ) u_channel (
      .clk_i     (clock),
      .rst_ni    (reset),
      .a_i       (channelA[ch]),
      .b_i       (channelB[ch]),
      .clear_i   (clear[ch]),
      .err_clr_i (error_clear[ch]),
      .pos_o     (pos_w),
      .err_o     (error[ch])
    );

    // Delta is taken one bit wider so a full-range swing cannot wrap before saturation.
    assign diff     = {pos_w[POS_WIDTH-1], pos_w} - {prev_q[POS_WIDTH-1], prev_q};
    assign diff_ext = {{(SAT_W-POS_WIDTH){diff[POS_WIDTH]}}, diff};
    assign vel_d    = tc ? VEL_WIDTH'(sat_signed(diff_ext, VEL_WIDTH)) : vel_q;
    assign prev_d   = clear[ch] ? '0 : (tc ? pos_w : prev_q);

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        prev_q <= '0;
        vel_q  <= '0;
      end else begin
        prev_q <= prev_d;
        vel_q  <= vel_d;
      end
    end

    assign position[ch*POS_WIDTH +: POS_WIDTH] = pos_w;
    assign velocity[ch*VEL_WIDTH +: VEL_WIDTH] = vel_q;
  end

endmodule

// File: tb/tb_quad_encoder_array.sv
// Directed bench for quad_encoder_array: an 8-bit-position instance for counting,
// wrap, filter and error behaviour, and a 16-bit-position instance for velocity.
module tb_quad_encoder_array;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  chA, chB, clr, eclr;
  logic [15:0] pos8;
  logic [15:0] vel8;
  logic        vv8;
  logic [1:0]  err8;
  logic [31:0] pos16;
  logic [15:0] vel16;
  logic        vv16;
  logic [1:0]  err16;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int st [2];

  quad_encoder_array #(
    .CHANNELS(2), .POS_WIDTH(8), .FILTER_CYCLES(4), .VEL_PERIOD(1000), .VEL_WIDTH(8)
  ) u_dut8 (
    .clock(clock), .reset(reset), .channelA(chA), .channelB(chB), .clear(clr),
    .error_clear(eclr), .position(pos8), .velocity(vel8), .velocity_valid(vv8), .error(err8)
  );

  quad_encoder_array #(
    .CHANNELS(2), .POS_WIDTH(16), .FILTER_CYCLES(4), .VEL_PERIOD(1000), .VEL_WIDTH(8)
  ) u_dut16 (
    .clock(clock), .reset(reset), .channelA(chA), .channelB(chB), .clear(clr),
    .error_clear(eclr), .position(pos16), .velocity(vel16), .velocity_valid(vv16), .error(err16)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         ch;
    int         steps;
    int         gap;
    logic [7:0] pos;
    logic       err;
  } vec_t;

  vec_t       vecs [7];
  logic [7:0] exp_last [2];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] ab_of(input int idx);
    case (idx)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic drive(input int ch);
    logic [1:0] ab;
    ab      = ab_of(st[ch]);
    chA[ch] = ab[1];
    chB[ch] = ab[0];
  endtask

  task automatic do_steps(input int ch, input int n, input int gap);
    int cnt;
    cnt = (n > 0) ? n : -n;
    for (int k = 0; k < cnt; k++) begin
      @(posedge clock); #1;
      st[ch] = (st[ch] + ((n > 0) ? 1 : 3)) % 4;
      drive(ch);
      repeat (gap - 1) @(posedge clock);
    end
  endtask

  task automatic wait_valid(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clock);
      if (vv16) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: velocity_valid not seen within 1100 cycles", nm);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    int t1;
    vecs[0] = '{0,   8, 20, 8'h08, 1'b0};
    vecs[1] = '{0,  -8, 12, 8'h00, 1'b0};
    vecs[2] = '{0,  -1, 12, 8'hFF, 1'b0};
    vecs[3] = '{0,   1, 12, 8'h00, 1'b0};
    vecs[4] = '{1,  -5, 10, 8'hFB, 1'b0};
    vecs[5] = '{1, 130,  8, 8'h7D, 1'b0};
    vecs[6] = '{1,   3,  8, 8'h80, 1'b0};
    exp_last[0] = 8'h00;
    exp_last[1] = 8'h00;
    st[0] = 0;
    st[1] = 0;

    reset = 1'b0;
    chA = 2'b00; chB = 2'b00; clr = 2'b00; eclr = 2'b00;
    #2;
    check("rst_pos8", {16'h0, pos8}, 32'h0);
    check("rst_err8", {30'h0, err8}, 32'h0);
    check("rst_vv8", {31'h0, vv8}, 32'h0);
    check("rst_vel16", {16'h0, vel16}, 32'h0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    repeat (10) @(posedge clock);

    for (int i = 0; i < 7; i++) begin
      do_steps(vecs[i].ch, vecs[i].steps, vecs[i].gap);
      repeat (8) @(posedge clock);
      @(negedge clock);
      exp_last[vecs[i].ch] = vecs[i].pos;
      check($sformatf("vec%0d_pos", i), {24'h0, pos8[vecs[i].ch*8 +: 8]}, {24'h0, vecs[i].pos});
      check($sformatf("vec%0d_other", i), {24'h0, pos8[(1-vecs[i].ch)*8 +: 8]},
            {24'h0, exp_last[1-vecs[i].ch]});
      check($sformatf("vec%0d_err", i), {31'h0, err8[vecs[i].ch]}, {31'h0, vecs[i].err});
    end

    // Latency: sampled at edge 1, visible at edge 7.
    @(posedge clock); #1;
    st[0] = (st[0] + 1) % 4;
    drive(0);
    repeat (6) @(posedge clock);
    @(negedge clock);
    check("lat_edge6", {24'h0, pos8[7:0]}, 32'h00);
    @(posedge clock);
    @(negedge clock);
    check("lat_edge7", {24'h0, pos8[7:0]}, 32'h01);

    // Three-cycle glitch on A is rejected.
    @(posedge clock); #1 chA[0] = ~chA[0];
    repeat (3) @(posedge clock);
    #1 chA[0] = ~chA[0];
    repeat (15) @(posedge clock);
    @(negedge clock);
    check("glitch_pos", {24'h0, pos8[7:0]}, 32'h01);

    // Clear on the same edge as a count wins and the step is discarded.
    @(posedge clock); #1;
    st[0] = (st[0] + 1) % 4;
    drive(0);
    repeat (6) @(posedge clock);
    #1 clr[0] = 1'b1;
    @(posedge clock);
    #1 clr[0] = 1'b0;
    @(negedge clock);
    check("clr_step", {24'h0, pos8[7:0]}, 32'h00);
    repeat (15) @(posedge clock);
    @(negedge clock);
    check("clr_hold", {24'h0, pos8[7:0]}, 32'h00);

    // Illegal double-bit transition on channel 1.
    @(posedge clock); #1;
    st[1] = (st[1] + 2) % 4;
    drive(1);
    repeat (12) @(posedge clock);
    @(negedge clock);
    check("illegal_err", {31'h0, err8[1]}, 32'h1);
    check("illegal_pos", {24'h0, pos8[15:8]}, 32'h80);
    check("illegal_err_other", {31'h0, err8[0]}, 32'h0);
    @(posedge clock); #1 eclr[1] = 1'b1;
    @(posedge clock); #1 eclr[1] = 1'b0;
    @(negedge clock);
    check("err_clear", {31'h0, err8[1]}, 32'h0);
    @(posedge clock); #1;
    st[1] = (st[1] + 2) % 4;
    drive(1);
    repeat (6) @(posedge clock);
    #1 eclr[1] = 1'b1;
    @(negedge clock);
    check("err_pre_set", {31'h0, err8[1]}, 32'h0);
    @(posedge clock);
    #1 eclr[1] = 1'b0;
    @(negedge clock);
    check("err_set_wins", {31'h0, err8[1]}, 32'h1);
    check("err_set_pos", {24'h0, pos8[15:8]}, 32'h80);

    // Velocity on the 16-bit instance.
    wait_valid("vv_first");
    t0 = cyc;
    do_steps(0, 50, 10);
    wait_valid("vv_50");
    t1 = cyc;
    check("vel_period", t1 - t0, 32'd1000);
    check("vel_50", {24'h0, vel16[7:0]}, 32'd50);
    check("vel_ch1_idle", {24'h0, vel16[15:8]}, 32'd0);
    @(negedge clock);
    check("vv_one_cycle", {31'h0, vv16}, 32'h0);
    do_steps(0, 300, 3);
    wait_valid("vv_300");
    check("vel_sat", {24'h0, vel16[7:0]}, 32'h7F);
    check("vel_sat_err", {31'h0, err16[0]}, 32'h0);

    // Reset in the middle of a step.
    @(posedge clock); #1;
    st[0] = (st[0] + 1) % 4;
    drive(0);
    repeat (3) @(posedge clock);
    #3 reset = 1'b0;
    #1;
    check("mid_rst_pos8", {16'h0, pos8}, 32'h0);
    check("mid_rst_err8", {30'h0, err8}, 32'h0);
    check("mid_rst_vv8", {31'h0, vv8}, 32'h0);
    check("mid_rst_vel8", {16'h0, vel8}, 32'h0);
    check("mid_rst_pos16", pos16, 32'h0);
    check("mid_rst_vel16", {16'h0, vel16}, 32'h0);
    check("mid_rst_err16", {30'h0, err16}, 32'h0);
    chA = 2'b11;
    chB = 2'b11;
    st[0] = 2;
    st[1] = 2;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    repeat (30) @(posedge clock);
    @(negedge clock);
    check("prime_pos8", {16'h0, pos8}, 32'h0);
    check("prime_err8", {30'h0, err8}, 32'h0);
    check("prime_pos16", pos16, 32'h0);
    check("prime_err16", {30'h0, err16}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
